// File: rtl/pic_control_logic.sv
// rtl/pic_control_logic.sv - 8259 PIC interrupt control core
// Holds IRR/ISR/IMR, resolves rotating priority and sequences the two-pulse INTA vector handshake.
module pic_control_logic (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cfg_we,
  input  logic [2:0] Flag,
  input  logic [7:0] cfg_data,
  input  logic [7:0] IR,
  input  logic       INTA_n,
  input  logic [2:0] read2control,
  output logic       INT,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [7:0] status_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACK1 = 2'd1;
  localparam logic [1:0] S_ACK2 = 2'd2;

  logic [7:0] irr_q, irr_d, isr_q, isr_d, imr_q, imr_d;
  logic [7:0] blk_q, blk_d;
  logic [4:0] t_q, t_d;
  logic       ltim_q, ltim_d, aeoi_q, aeoi_d, rot_aeoi_q, rot_aeoi_d;
  logic [2:0] lowest_q, lowest_d, win_q, win_d;
  logic [7:0] ir_q;
  logic       inta_q;
  logic [1:0] state_q, state_d;
  logic       int_q, int_d, data_oe_q, data_oe_d;
  logic [7:0] data_out_q, data_out_d;

  logic [7:0] pend, ack_mask, eoi_clr, aeoi_clr;
  logic [3:0] p_top, s_top;
  logic       req, inta_fall, inta_rise, icw1;
  logic [2:0] lvl;

  // Returns {found, index} of the highest-priority set bit; priority runs low+1 .. low.
  function automatic logic [3:0] top_bit(input logic [7:0] m, input logic [2:0] low);
    logic [3:0] r;
    logic [2:0] idx;
    r = 4'd0;
    for (int i = 8; i >= 1; i--) begin
      idx = low + 3'(i);
      if (m[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  function automatic logic [2:0] rank(input logic [2:0] idx, input logic [2:0] low);
    return idx - low - 3'd1;
  endfunction

  assign pend      = irr_q & ~imr_q;
  assign p_top     = top_bit(pend, lowest_q);
  assign s_top     = top_bit(isr_q, lowest_q);
  assign req       = p_top[3] && (!s_top[3] || (rank(p_top[2:0], lowest_q) < rank(s_top[2:0], lowest_q)));
  assign inta_fall = inta_q & ~INTA_n;
  assign inta_rise = ~inta_q & INTA_n;
  assign icw1      = cfg_we && (Flag == 3'd0);
  assign lvl       = cfg_data[2:0];

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    lowest_d   = lowest_q;
    rot_aeoi_d = rot_aeoi_q;
    aeoi_d     = aeoi_q;
    ltim_d     = ltim_q;
    t_d        = t_q;
    imr_d      = imr_q;
    ack_mask   = 8'd0;
    eoi_clr    = 8'd0;
    aeoi_clr   = 8'd0;

    case (state_q)
      S_IDLE: if (inta_fall) begin
        state_d = S_ACK1;
        if (req) begin
          win_d    = p_top[2:0];
          ack_mask = 8'd1 << p_top[2:0];
        end else begin
          win_d = 3'd7;
        end
      end
      S_ACK1: if (inta_fall) begin
        state_d    = S_ACK2;
        data_out_d = {t_q, win_q};
        data_oe_d  = 1'b1;
      end
      S_ACK2: if (inta_rise) begin
        state_d   = S_IDLE;
        data_oe_d = 1'b0;
        if (aeoi_q) begin
          aeoi_clr = 8'd1 << win_q;
          if (rot_aeoi_q) lowest_d = win_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cfg_we) begin
      case (Flag)
        3'd1: t_d    = cfg_data[7:3];
        3'd3: aeoi_d = cfg_data[1];
        3'd4: imr_d  = cfg_data;
        3'd5: case (cfg_data[7:5])
          3'b001: if (s_top[3]) eoi_clr = 8'd1 << s_top[2:0];
          3'b011: eoi_clr = 8'd1 << lvl;
          3'b101: if (s_top[3]) begin
            eoi_clr  = 8'd1 << s_top[2:0];
            lowest_d = s_top[2:0];
          end
          3'b111: begin
            eoi_clr  = 8'd1 << lvl;
            lowest_d = lvl;
          end
          3'b110: lowest_d = lvl;
          3'b100: rot_aeoi_d = 1'b1;
          3'b000: rot_aeoi_d = 1'b0;
          default: ;
        endcase
        default: ;
      endcase
    end

    // An acknowledge setting a bit beats any clear of that bit in the same cycle.
    isr_d = (isr_q & ~eoi_clr & ~aeoi_clr) | ack_mask;
    // Level mode: an acknowledged line stays blocked until it drops low.
    blk_d = ltim_q ? ((blk_q | ack_mask) & IR) : 8'd0;
    irr_d = ltim_q ? (IR & ~blk_d) : ((irr_q & ~ack_mask) | (IR & ~ir_q));
    int_d = (state_q == S_IDLE) && !inta_fall && req;

    if (icw1) begin
      irr_d      = 8'd0;
      isr_d      = 8'd0;
      imr_d      = 8'd0;
      blk_d      = 8'd0;
      lowest_d   = 3'd7;
      aeoi_d     = 1'b0;
      rot_aeoi_d = 1'b0;
      ltim_d     = cfg_data[3];
      state_d    = S_IDLE;
      int_d      = 1'b0;
      data_oe_d  = 1'b0;
      data_out_d = 8'd0;
    end
  end

  always_ff @(posedge CLK) begin
    ir_q   <= IR;
    inta_q <= INTA_n;
    if (RST) begin
      irr_q      <= 8'd0;
      isr_q      <= 8'd0;
      imr_q      <= 8'd0;
      blk_q      <= 8'd0;
      t_q        <= 5'd0;
      ltim_q     <= 1'b0;
      aeoi_q     <= 1'b0;
      rot_aeoi_q <= 1'b0;
      lowest_q   <= 3'd7;
      win_q      <= 3'd0;
      state_q    <= S_IDLE;
      int_q      <= 1'b0;
      data_oe_q  <= 1'b0;
      data_out_q <= 8'd0;
    end else begin
      irr_q      <= irr_d;
      isr_q      <= isr_d;
      imr_q      <= imr_d;
      blk_q      <= blk_d;
      t_q        <= t_d;
      ltim_q     <= ltim_d;
      aeoi_q     <= aeoi_d;
      rot_aeoi_q <= rot_aeoi_d;
      lowest_q   <= lowest_d;
      win_q      <= win_d;
      state_q    <= state_d;
      int_q      <= int_d;
      data_oe_q  <= data_oe_d;
      data_out_q <= data_out_d;
    end
  end

  always_comb begin
    status_out = 8'd0;
    case (read2control)
      3'b011:         status_out = imr_q;
      3'b001, 3'b111: status_out = irr_q;
      3'b101:         status_out = isr_q;
      default:        status_out = 8'd0;
    endcase
  end

  assign INT      = int_q;
  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;

endmodule

// File: doc/pic_control_logic.md
# pic_control_logic

Interrupt control core of the 8259 PIC. It consumes configuration bytes classified by the read/write logic (`Flag` plus data byte) and holds IRR, ISR and IMR. It resolves priority with optional rotation, drives INT, and sequences the two-pulse INTA handshake that places the vector on the data bus. It also supplies the status byte selected by `read2control`.

## Interface
- No parameters; 8 IR lines fixed by the 8259 architecture.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  one-cycle strobe: `Flag`/`cfg_data` valid.
- `Flag`  in  3  register written: 0 ICW1, 1 ICW2, 2 ICW3, 3 ICW4, 4 OCW1, 5 OCW2, 6 OCW3.
- `cfg_data`  in  8  written byte.
- `IR`  in  8  interrupt request lines, active-high.
- `INTA_n`  in  1  interrupt acknowledge, active-low, synchronous to CLK.
- `read2control`  in  3  status select: 3'b011 IMR, 3'b001/3'b111 IRR, 3'b101 ISR.
- `INT`  out  1  interrupt to CPU, registered.
- `data_out`  out  8  vector byte, registered.
- `data_oe`  out  1  vector drive enable, registered.
- `status_out`  out  8  combinational mux of IMR/IRR/ISR per `read2control`; 0 for other codes.

## Operation
- State: IRR, ISR, IMR, `T[4:0]` vector base, LTIM, AEOI, `rot_aeoi`, `lowest[2:0]` (lowest-priority IR), `ir_q` (previous IR), `inta_q`, `win[2:0]`, FSM.
- Reset / ICW1 write: IRR=ISR=IMR=0, `lowest`=7 (IR0 highest), AEOI=0, `rot_aeoi`=0, FSM→IDLE, INT=0, data_oe=0, data_out=0, `ir_q`=IR (no false edges). ICW1 also sets LTIM=`cfg_data[3]`. ICW1 write mid-INTA aborts the sequence.
- ICW2: `T`=`cfg_data[7:3]`. ICW3: ignored (cascade out of scope). ICW4: AEOI=`cfg_data[1]`. OCW1: IMR=`cfg_data`. OCW3: no effect here.
- OCW2, `{R,SL,EOI}`=`cfg_data[7:5]`, `L`=`cfg_data[2:0]`:
  - 001 non-specific EOI: clear the highest-priority set ISR bit.
  - 011 specific EOI: clear ISR[L].
  - 101 rotate on non-specific EOI: clear that bit `b`; `lowest`=`b`.
  - 111 rotate on specific EOI: clear ISR[L]; `lowest`=L.
  - 110 set priority: `lowest`=L.
  - 100 / 000: `rot_aeoi`=1 / 0.
  - 010: no-op.
  - Non-specific EOI with ISR=0: no change.
- IRR:
  - Edge mode (LTIM=0): bit set on `IR & ~ir_q`; stays set until acknowledged.
  - Level mode: IRR = IR, except a bit cleared by acknowledge stays clear until IR falls and rises again.
- Priority order: `lowest+1`, `lowest+2`, … `lowest` (mod 8). Pending = IRR & ~IMR.
- `req` = highest-priority pending bit outranks the highest-priority ISR bit (fully nested; equal or lower priority is blocked).
- INT is registered `req` while FSM=IDLE, and 0 otherwise.
- FSM:
  - IDLE→ACK1 on INTA fall (`inta_q & ~INTA_n`). If `req`: `win`=winner, ISR[win]=1, IRR[win]=0. Else spurious: `win`=7 and ISR is unchanged.
  - ACK1→ACK2 on the second INTA fall: data_out={T,win}, data_oe=1.
  - ACK2→IDLE on INTA rise: data_oe=0. If AEOI, clear ISR[win]; if also `rot_aeoi`, `lowest`=win.
- Simultaneous events:
  - ICW1 overrides everything.
  - EOI evaluates the pre-cycle ISR; set-by-ack wins over clear of the same bit.
  - A new IR edge wins over the ack clear of the same IRR bit.
  - INTA falls seen while in ACK2 are ignored.

## Timing
- Edge mode: IR rises before edge k → IRR set at edge k → INT high after edge k+1 (2-cycle latency).
- INTA fall sampled at edge m: ISR/IRR update at edge m; INT low after edge m.
- Vector: data_oe/data_out valid after the edge sampling the second fall. data_oe drops after the edge sampling the rise.
- `cfg_we` effects are visible the cycle after the strobe.
- status_out is zero-latency from register state.

## Test plan
- Reset, ICW1=0x13, ICW2=0x20, ICW4=0x01, pulse IR3 → INT high 2 cycles later. Two INTA pulses → data_out=0x23, data_oe only during the second pulse, ISR=0x08, IRR=0.
- IR2 and IR5 simultaneous, IMR=0 → first ack vectors IR2. INT stays low until OCW2=0x20 (non-specific EOI) clears ISR[2], then IR5 is served.
- OCW2=0xC4 (set priority, lowest=4), IR3 and IR6 pending → IR6 wins. OCW1=0x40 → IR3 wins.
- Level mode (ICW1=0x1B): IR1 held high, acked → IRR[1] stays clear until IR1 falls and rises again. INTA with no request → vector {T,7}, ISR unchanged.
- AEOI with rotate (ICW4=0x03, OCW2=0x80): ack IR0 → ISR clear after the second INTA rises, `lowest`=0, so IR1 now has highest priority.
- ICW1 written between the two INTA pulses → FSM IDLE, INT=0, data_oe never asserts, IRR/ISR/IMR=0.
